// File: rtl/parking_pkg.sv
// Shared types and helpers for the parking-lot occupancy manager.
package parking_pkg;

    // Per-gate passage tracker states.
    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        A_ONLY   = 4'd1,
        B_ONLY   = 4'd2,
        AB_IN    = 4'd3,
        AB_OUT   = 4'd4,
        IN_TAIL  = 4'd5,
        OUT_TAIL = 4'd6,
        ENTERED  = 4'd7,
        EXITED   = 4'd8
    } gate_state_t;

    // Number of set bits in a (zero-extended) vector of up to 64 gates.
    function automatic logic [7:0] popcount(input logic [63:0] v);
        logic [7:0] sum;
        sum = '0;
        for (int i = 0; i < 64; i++) begin
            sum = sum + 8'(v[i]);
        end
        return sum;
    endfunction

endpackage

// File: rtl/parking_gate.sv
// One gate: debounces the outer (a) and inner (b) sensors and tracks the
// order in which they are blocked, emitting one-cycle enter/exit pulses.
module parking_gate
    import parking_pkg::*;
#(
    parameter int DB_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic i_a,
    input  logic i_b,
    output logic o_enter,
    output logic o_exit
);

    localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;

    logic [1:0]    w_raw;
    logic [1:0]    r_filt;      // bit 1 = filtered a, bit 0 = filtered b
    logic [CW-1:0] r_cnt [2];
    gate_state_t   r_state;
    logic          r_enter;
    logic          r_exit;

    assign w_raw = {i_a, i_b};

    // Debounce: a raw level must disagree with the filtered value for
    // DB_CYCLES consecutive cycles before it is accepted.
    always_ff @(posedge clk) begin
        for (int s = 0; s < 2; s++) begin
            if (reset) begin
                r_filt[s] <= 1'b0;
                r_cnt[s]  <= '0;
            end else if (w_raw[s] == r_filt[s]) begin
                r_cnt[s]  <= '0;
            end else if (r_cnt[s] == CW'(DB_CYCLES - 1)) begin
                r_filt[s] <= w_raw[s];
                r_cnt[s]  <= '0;
            end else begin
                r_cnt[s]  <= r_cnt[s] + 1'b1;
            end
        end
    end

    // Passage FSM on filtered {a,b}; pulses are registered together with
    // the transition into ENTERED/EXITED so they track the state exactly.
    always_ff @(posedge clk) begin
        gate_state_t v_next;
        if (reset) begin
            r_state <= IDLE;
            r_enter <= 1'b0;
            r_exit  <= 1'b0;
        end else begin
            v_next = r_state;
            case (r_state)
                IDLE: begin
                    if (r_filt == 2'b10)      v_next = A_ONLY;
                    else if (r_filt == 2'b01) v_next = B_ONLY;
                end
                A_ONLY: begin
                    if (r_filt == 2'b11)      v_next = AB_IN;
                    else if (r_filt == 2'b01) v_next = B_ONLY;
                    else if (r_filt == 2'b00) v_next = IDLE;
                end
                B_ONLY: begin
                    if (r_filt == 2'b11)      v_next = AB_OUT;
                    else if (r_filt == 2'b10) v_next = A_ONLY;
                    else if (r_filt == 2'b00) v_next = IDLE;
                end
                AB_IN: begin
                    if (r_filt == 2'b01)      v_next = IN_TAIL;
                    else if (r_filt == 2'b10) v_next = A_ONLY;
                    else if (r_filt == 2'b00) v_next = IDLE;
                end
                AB_OUT: begin
                    if (r_filt == 2'b10)      v_next = OUT_TAIL;
                    else if (r_filt == 2'b01) v_next = B_ONLY;
                    else if (r_filt == 2'b00) v_next = IDLE;
                end
                IN_TAIL: begin
                    if (r_filt == 2'b00)      v_next = ENTERED;
                    else if (r_filt == 2'b11) v_next = AB_IN;
                    else if (r_filt == 2'b10) v_next = IDLE;
                end
                OUT_TAIL: begin
                    if (r_filt == 2'b00)      v_next = EXITED;
                    else if (r_filt == 2'b11) v_next = AB_OUT;
                    else if (r_filt == 2'b01) v_next = IDLE;
                end
                ENTERED:  v_next = IDLE;
                EXITED:   v_next = IDLE;
                default:  v_next = IDLE;
            endcase
            r_state <= v_next;
            r_enter <= (v_next == ENTERED);
            r_exit  <= (v_next == EXITED);
        end
    end

    assign o_enter = r_enter;
    assign o_exit  = r_exit;

endmodule

// File: rtl/parking_lot_manager.sv
// Multi-gate parking-lot occupancy manager: N_GATES debounced gates feed
// one saturating occupancy counter with sticky overflow/underflow flags.
module parking_lot_manager
    import parking_pkg::*;
#(
    parameter  int N_GATES   = 2,
    parameter  int CAPACITY  = 15,
    parameter  int DB_CYCLES = 4,
    localparam int CNT_W     = $clog2(CAPACITY + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N_GATES-1:0] a,
    input  logic [N_GATES-1:0] b,
    input  logic               clr,
    output logic [N_GATES-1:0] enter_pulse,
    output logic [N_GATES-1:0] exit_pulse,
    output logic [CNT_W-1:0]   occupancy,
    output logic               full,
    output logic               empty,
    output logic               err_overflow,
    output logic               err_underflow
);

    // Signed width wide enough for occupancy plus all gates entering, or
    // zero minus all gates exiting.
    localparam int TW = CNT_W + $clog2(N_GATES + 1) + 1;
    localparam logic signed [TW-1:0] CAP_S = TW'(CAPACITY);

    logic [N_GATES-1:0]     w_enter;
    logic [N_GATES-1:0]     w_exit;
    logic [7:0]             w_n_in;
    logic [7:0]             w_n_out;
    logic signed [TW-1:0]   w_t;
    logic [CNT_W-1:0]       r_occ;
    logic                   r_err_ovf;
    logic                   r_err_unf;

    for (genvar g = 0; g < N_GATES; g++) begin : g_gate
        parking_gate #(
            .DB_CYCLES (DB_CYCLES)
        ) u_gate (
            .clk     (clk),
            .reset   (reset),
            .i_a     (a[g]),
            .i_b     (b[g]),
            .o_enter (w_enter[g]),
            .o_exit  (w_exit[g])
        );
    end

    assign w_n_in  = popcount(64'(w_enter));
    assign w_n_out = popcount(64'(w_exit));
    assign w_t     = $signed(TW'(r_occ)) + $signed(TW'(w_n_in)) - $signed(TW'(w_n_out));

    // Net all gate events each cycle, saturate at 0/CAPACITY, latch errors.
    always_ff @(posedge clk) begin
        if (reset || clr) begin
            r_occ     <= '0;
            r_err_ovf <= 1'b0;
            r_err_unf <= 1'b0;
        end else if (w_t > CAP_S) begin
            r_occ     <= CNT_W'(CAPACITY);
            r_err_ovf <= 1'b1;
        end else if (w_t < 0) begin
            r_occ     <= '0;
            r_err_unf <= 1'b1;
        end else begin
            r_occ     <= w_t[CNT_W-1:0];
        end
    end

    assign enter_pulse   = w_enter;
    assign exit_pulse    = w_exit;
    assign occupancy     = r_occ;
    assign full          = (r_occ == CNT_W'(CAPACITY));
    assign empty         = (r_occ == '0);
    assign err_overflow  = r_err_ovf;
    assign err_underflow = r_err_unf;

endmodule

// File: tb/tb_parking_lot_manager.sv
// Bench for parking_lot_manager: directed scenarios, then random lockstep
// rounds of whole sensor sequences scored against a count-level model.
module tb_parking_lot_manager;

    localparam int N_GATES   = 2;
    localparam int CAPACITY  = 3;
    localparam int DB_CYCLES = 2;

    // Sensor sequences, four {a,b} steps each, first step in the top bits.
    localparam logic [7:0] SEQ_ENTRY   = 8'b10_11_01_00;
    localparam logic [7:0] SEQ_EXIT    = 8'b01_11_10_00;
    localparam logic [7:0] SEQ_ABORT_A = 8'b10_11_10_00;
    localparam logic [7:0] SEQ_ABORT_B = 8'b01_11_01_00;
    localparam logic [7:0] SEQ_IDLE    = 8'b00_00_00_00;

    logic               clk;
    logic               reset;
    logic [N_GATES-1:0] a;
    logic [N_GATES-1:0] b;
    logic               clr;
    logic [N_GATES-1:0] enter_pulse;
    logic [N_GATES-1:0] exit_pulse;
    logic [1:0]         occupancy;
    logic               full;
    logic               empty;
    logic               err_overflow;
    logic               err_underflow;

    int n_err = 0;
    int n_chk = 0;

    // Reference model state.
    int m_occ;
    bit m_ovf;
    bit m_unf;
    int m_en [N_GATES];
    int m_ex [N_GATES];

    // Observed pulse-cycle counts and occupancy around a pulse.
    int en_cnt [N_GATES];
    int ex_cnt [N_GATES];
    int occ_at_pulse;
    int occ_after_pulse;
    bit pend;

    parking_lot_manager #(
        .N_GATES   (N_GATES),
        .CAPACITY  (CAPACITY),
        .DB_CYCLES (DB_CYCLES)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .a             (a),
        .b             (b),
        .clr           (clr),
        .enter_pulse   (enter_pulse),
        .exit_pulse    (exit_pulse),
        .occupancy     (occupancy),
        .full          (full),
        .empty         (empty),
        .err_overflow  (err_overflow),
        .err_underflow (err_underflow)
    );

    // Clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse monitor, sampled on the falling edge.
    always @(negedge clk) begin
        for (int g = 0; g < N_GATES; g++) begin
            if (enter_pulse[g]) en_cnt[g]++;
            if (exit_pulse[g])  ex_cnt[g]++;
        end
        if (|enter_pulse || |exit_pulse) begin
            occ_at_pulse = int'(occupancy);
            pend = 1'b1;
        end else if (pend) begin
            occ_after_pulse = int'(occupancy);
            pend = 1'b0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick(3);
        reset = 1'b0;
        m_occ = 0;
        m_ovf = 0;
        m_unf = 0;
    endtask

    task automatic do_clr();
        clr = 1'b1;
        tick(1);
        clr = 1'b0;
        m_occ = 0;
        m_ovf = 0;
        m_unf = 0;
    endtask

    // Drive both gates in lockstep, each step held 4 cycles, then settle.
    task automatic play(input logic [7:0] p0, input logic [7:0] p1);
        logic [7:0] s0;
        logic [7:0] s1;
        for (int i = 0; i < 4; i++) begin
            s0 = p0 >> (2 * (3 - i));
            s1 = p1 >> (2 * (3 - i));
            a = {s1[1], s0[1]};
            b = {s1[0], s0[0]};
            tick(4);
        end
        tick(4);
    endtask

    // Model: whole sequences map to events; simultaneous events net out.
    task automatic model_round(input logic [7:0] p0, input logic [7:0] p1);
        int n_in;
        int n_out;
        int t;
        n_in  = int'(p0 == SEQ_ENTRY) + int'(p1 == SEQ_ENTRY);
        n_out = int'(p0 == SEQ_EXIT)  + int'(p1 == SEQ_EXIT);
        m_en[0] += int'(p0 == SEQ_ENTRY);
        m_en[1] += int'(p1 == SEQ_ENTRY);
        m_ex[0] += int'(p0 == SEQ_EXIT);
        m_ex[1] += int'(p1 == SEQ_EXIT);
        t = m_occ + n_in - n_out;
        if (t > CAPACITY) begin
            m_occ = CAPACITY;
            m_ovf = 1;
        end else if (t < 0) begin
            m_occ = 0;
            m_unf = 1;
        end else begin
            m_occ = t;
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".occ"},   32'(occupancy),     32'(m_occ));
        chk({tag, ".full"},  32'(full),          32'(m_occ == CAPACITY));
        chk({tag, ".empty"}, 32'(empty),         32'(m_occ == 0));
        chk({tag, ".ovf"},   32'(err_overflow),  32'(m_ovf));
        chk({tag, ".unf"},   32'(err_underflow), 32'(m_unf));
        for (int g = 0; g < N_GATES; g++) begin
            chk($sformatf("%s.en%0d", tag, g), 32'(en_cnt[g]), 32'(m_en[g]));
            chk($sformatf("%s.ex%0d", tag, g), 32'(ex_cnt[g]), 32'(m_ex[g]));
        end
    endtask

    task automatic round(input string tag, input logic [7:0] p0, input logic [7:0] p1);
        play(p0, p1);
        model_round(p0, p1);
        check_all(tag);
    endtask

    initial begin
        logic [7:0] seqs [5];
        logic [7:0] r0;
        logic [7:0] r1;
        seqs[0] = SEQ_ENTRY;
        seqs[1] = SEQ_EXIT;
        seqs[2] = SEQ_ABORT_A;
        seqs[3] = SEQ_ABORT_B;
        seqs[4] = SEQ_IDLE;
        for (int g = 0; g < N_GATES; g++) begin
            en_cnt[g] = 0;
            ex_cnt[g] = 0;
            m_en[g]   = 0;
            m_ex[g]   = 0;
        end
        pend = 1'b0;
        occ_at_pulse = 99;
        occ_after_pulse = 99;
        a = '0;
        b = '0;
        clr = 1'b0;
        reset = 1'b0;
        tick(1);
        do_reset();

        // Reset state.
        chk("reset.pulses", 32'({enter_pulse, exit_pulse}), 32'd0);
        check_all("reset");

        // 1: single entry on gate 0; occupancy moves on the edge after the pulse.
        round("t1", SEQ_ENTRY, SEQ_IDLE);
        chk("t1.occ_during_pulse", 32'(occ_at_pulse), 32'd0);
        chk("t1.occ_after_pulse",  32'(occ_after_pulse), 32'd1);

        // 2: one-cycle glitch on a[0] is filtered out.
        a = 2'b01;
        tick(1);
        a = 2'b00;
        tick(8);
        check_all("t2");

        // 3: entry + exit net to zero, then two entries reach capacity.
        round("t3a", SEQ_ENTRY, SEQ_EXIT);
        round("t3b", SEQ_ENTRY, SEQ_ENTRY);

        // 4: entry at capacity overflows and sticks; clr clears.
        round("t4a", SEQ_ENTRY, SEQ_IDLE);
        tick(6);
        check_all("t4b");
        do_clr();
        check_all("t4c");

        // 5: exit at zero underflows.
        round("t5", SEQ_IDLE, SEQ_EXIT);

        // 6: abort gives no pulse; reset in AB_IN discards the partial entry.
        round("t6a", SEQ_ABORT_A, SEQ_IDLE);
        a = 2'b01; b = 2'b00; tick(4);
        a = 2'b01; b = 2'b01; tick(4);
        do_reset();
        check_all("t6b");
        a = 2'b00; b = 2'b01; tick(4);
        a = 2'b00; b = 2'b00; tick(8);
        check_all("t6c");

        // Random lockstep rounds with occasional clears.
        for (int r = 0; r < 30; r++) begin
            r0 = seqs[$urandom_range(0, 4)];
            r1 = seqs[$urandom_range(0, 4)];
            round($sformatf("rnd%0d", r), r0, r1);
            if ($urandom_range(0, 5) == 0) begin
                do_clr();
                check_all($sformatf("rnd%0d.clr", r));
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
